// File: rtl/mem_model_pkg.sv
// Shared definitions for the pipelined memory model: request rw encoding and the
// response record layout {data,id} at the default widths.
package mem_model_pkg;

    localparam logic MEM_RD = 1'b0;
    localparam logic MEM_WR = 1'b1;

    localparam int RESP_DATA_BITS = 32;
    localparam int RESP_ID_BITS   = 4;

    typedef struct packed {
        logic [RESP_DATA_BITS-1:0] data;
        logic [RESP_ID_BITS-1:0]   id;
    } resp_t;

endpackage

// File: rtl/mem_resp_fifo.sv
// Response FIFO for mem_model_pipe; DEPTH need not be a power of two, pointers
// wrap explicitly. A push into a full FIFO is taken only together with a pop.
module mem_resp_fifo
#(
    parameter int WIDTH = 36,
    parameter int DEPTH = 8
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] slots [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return ptr + PTR_W'(1);
        end
    endfunction

    assign empty     = (count == {CNT_W{1'b0}});
    assign full      = (count == CNT_W'(DEPTH));
    assign do_pop    = pop & ~empty;
    assign do_push   = push & (~full | do_pop);
    assign head_data = slots[rd_ptr];

    // Storage and pointer/occupancy update
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= {WIDTH{1'b0}};
            end
            rd_ptr <= {PTR_W{1'b0}};
            wr_ptr <= {PTR_W{1'b0}};
            count  <= {CNT_W{1'b0}};
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_data;
                wr_ptr        <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_model_pipe.sv
// Pipelined memory model: single-cycle writes, fixed-latency reads through a delay
// line into a response FIFO. Define MEM_MODEL_WRITE_ACK_EN to also acknowledge writes.
module mem_model_pipe
    import mem_model_pkg::*;
#(
    parameter int LINE_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int LINE_BITS    = 5,
    parameter int INDEX_BITS   = 9,
    parameter int CREG_ID_BITS = 4,
    parameter int LATENCY      = 8,
    parameter int DEPTH        = 8
)
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic [ADDR_WIDTH-1:0]   addr_in,
    input  logic [LINE_WIDTH-1:0]   data_in,
    input  logic                    rw_in,
    input  logic                    valid_in,
    input  logic [CREG_ID_BITS-1:0] id_in,
    input  logic                    accept_in,
    output logic [LINE_WIDTH-1:0]   data_out,
    output logic [CREG_ID_BITS-1:0] id_out,
    output logic                    ready_out,
    output logic                    stall_out
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int WORDS   = 2 ** INDEX_BITS;
    localparam int ENTRY_W = LINE_WIDTH + CREG_ID_BITS;

    // Same layout as resp_t, sized by this instance's parameters
    typedef struct packed {
        logic [LINE_WIDTH-1:0]   data;
        logic [CREG_ID_BITS-1:0] id;
    } entry_t;

    logic [LINE_WIDTH-1:0] mem_array [WORDS];
    logic [INDEX_BITS-1:0] idx;
    logic                  accept;
    logic                  resp_accept;
    logic                  pop;
    entry_t                in_entry;
    entry_t                out_entry;
    logic                  out_valid;
    logic [CNT_W-1:0]      outstanding;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [ENTRY_W-1:0]    head;
    logic                  unused_addr;

    assign idx         = addr_in[INDEX_BITS+LINE_BITS-1:LINE_BITS];
    assign unused_addr = ^addr_in;
    assign stall_out   = fifo_full | (outstanding == CNT_W'(DEPTH));
    assign accept      = valid_in & ~stall_out;
    assign ready_out   = ~fifo_empty;
    assign pop         = ready_out & accept_in;
    assign data_out    = head[ENTRY_W-1:CREG_ID_BITS];
    assign id_out      = head[CREG_ID_BITS-1:0];

    // Form the response record for an accepted request
    always_comb begin
        in_entry.id = id_in;
        if (rw_in == MEM_WR) begin
            in_entry.data = {LINE_WIDTH{1'b0}};
`ifdef MEM_MODEL_WRITE_ACK_EN
            resp_accept   = accept;
`else
            resp_accept   = 1'b0;
`endif
        end else begin
            in_entry.data = mem_array[idx];
            resp_accept   = accept;
        end
    end

    // Memory array: cleared on reset, written on accepted writes
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WORDS; i++) begin
                mem_array[i] <= {LINE_WIDTH{1'b0}};
            end
        end else if (accept && (rw_in == MEM_WR)) begin
            mem_array[idx] <= data_in;
        end
    end

    // Outstanding responses in delay line plus FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            outstanding <= {CNT_W{1'b0}};
        end else begin
            case ({resp_accept, pop})
                2'b10:   outstanding <= outstanding + CNT_W'(1);
                2'b01:   outstanding <= outstanding - CNT_W'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // LATENCY-1 register stages; the FIFO push edge supplies the final cycle
    generate
        if (LATENCY > 1) begin : g_delay
            logic   stage_valid [LATENCY-1];
            entry_t stage_data  [LATENCY-1];

            // Shift accepted requests toward the FIFO
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int s = 0; s < LATENCY - 1; s++) begin
                        stage_valid[s] <= 1'b0;
                        stage_data[s]  <= {ENTRY_W{1'b0}};
                    end
                end else begin
                    stage_valid[0] <= resp_accept;
                    stage_data[0]  <= in_entry;
                    for (int s = 1; s < LATENCY - 1; s++) begin
                        stage_valid[s] <= stage_valid[s-1];
                        stage_data[s]  <= stage_data[s-1];
                    end
                end
            end

            assign out_valid = stage_valid[LATENCY-2];
            assign out_entry = stage_data[LATENCY-2];
        end else begin : g_direct
            assign out_valid = resp_accept;
            assign out_entry = in_entry;
        end
    endgenerate

    mem_resp_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_resp_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (out_valid),
        .push_data (out_entry),
        .pop       (pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: doc/mem_model_pipe.md
MEM_MODEL_PIPE -- requirements
Module: mem_model_pipe

Interface
REQ-001 SHALL have parameter LINE_WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-003 SHALL have parameter LINE_BITS, default 5, low address bits ignored for indexing.
REQ-004 SHALL have parameter INDEX_BITS, default 9, word index width; the array holds 2^INDEX_BITS words.
REQ-005 SHALL have parameter CREG_ID_BITS, default 4, ld/st queue id width.
REQ-006 SHALL have parameter LATENCY, default 8, read latency in cycles, legal range 1..32.
REQ-007 SHALL have parameter DEPTH, default 8, maximum outstanding responses, legal range 2..64.
REQ-008 SHALL have port clk, input, 1, the single clock; reset is synchronous and active-high.
REQ-009 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-010 SHALL have port addr_in, input, ADDR_WIDTH, request address; the index is bits [INDEX_BITS+LINE_BITS-1:LINE_BITS].
REQ-011 SHALL have port data_in, input, LINE_WIDTH, write data.
REQ-012 SHALL have port rw_in, input, 1, 1 = write, 0 = read.
REQ-013 SHALL have port valid_in, input, 1, request valid.
REQ-014 SHALL have port id_in, input, CREG_ID_BITS, request id.
REQ-015 SHALL have port accept_in, input, 1, consumer takes the current response.
REQ-016 SHALL have port data_out, output, LINE_WIDTH, response data.
REQ-017 SHALL have port id_out, output, CREG_ID_BITS, response id.
REQ-018 SHALL have port ready_out, output, 1, response valid.
REQ-019 SHALL have port stall_out, output, 1, new request not accepted this cycle.

Function
REQ-020 SHALL accept a request in a cycle where valid_in=1 and stall_out=0; in all other cycles the request is ignored.
REQ-021 SHALL perform an accepted write into the array at that clock edge; the next cycle's read of the same index returns the new data.
REQ-022 SHALL sample read data from the array at acceptance and carry {data,id} through a LATENCY-stage delay line into a DEPTH-entry response FIFO.
REQ-023 SHALL assert ready_out exactly LATENCY cycles after read acceptance when the FIFO is empty.
REQ-024 SHALL deliver responses in acceptance order.
REQ-025 SHALL pop the FIFO head on ready_out=1 and accept_in=1; while ready_out=1 and accept_in=0, data_out/id_out SHALL hold stable.
REQ-026 SHALL keep a counter of outstanding responses (delay line plus FIFO), width $clog2(DEPTH+1); stall_out=1 iff counter==DEPTH; the FIFO therefore never overflows.
REQ-027 SHALL handle a simultaneous accept and pop by leaving the counter unchanged; it increments on accept only and decrements on pop only.
REQ-028 SHALL ignore accept_in when ready_out=0.
REQ-029 SHALL keep the FIFO pointers wrapping modulo DEPTH; DEPTH need not be a power of two.
REQ-030 SHALL let an entry arriving from the delay line in the same cycle as a pop enter the FIFO without loss.

Reset
REQ-031 SHALL clear the delay line, FIFO pointers and counter on reset=1 at a clock edge, and zero the array; ready_out=0, stall_out=0, data_out=0, id_out=0.
REQ-032 SHALL discard in-flight requests on reset mid-operation and produce no response for them afterwards.

Configuration
REQ-033 SHALL, with macro MEM_MODEL_WRITE_ACK_EN defined, enqueue a write response (id_in, data_out=0) LATENCY cycles after write acceptance, counted against DEPTH; undefined, writes produce no response and do not occupy DEPTH.

Structure
REQ-034 SHALL place the rw encoding constants (MEM_RD=0, MEM_WR=1) and the response struct type {data,id} in the shared package mem_model_pkg.
REQ-035 SHALL implement the response FIFO as sub-module mem_resp_fifo (parameters WIDTH and DEPTH; push/pop/full/empty).

Verification
REQ-036 SHALL cover: write idx 3 = 0xDEADBEEF, then read idx 3 id 5 -> ready_out at +8 cycles, data_out 0xDEADBEEF, id_out 5.
REQ-037 SHALL cover: 8 back-to-back reads with accept_in=0 -> stall_out=1 on the 9th cycle; one pop -> stall_out=0 next cycle.
REQ-038 SHALL cover: reads id 1,2,3 with accept_in toggling 1/0 -> ids out in order 1,2,3 with outputs stable while unaccepted.
REQ-039 SHALL cover: read plus pop in the same cycle at counter==DEPTH-1 -> counter stays DEPTH-1, stall_out stays 0.
REQ-040 SHALL cover: reset asserted 3 cycles after 4 reads -> no ready_out afterwards, array reads return 0.
REQ-041 SHALL cover: with MEM_MODEL_WRITE_ACK_EN, write id 9 -> ready_out at +8 cycles with id_out 9, data_out 0.
